// File: rtl/register_file.sv
// Purpose : 2**ADDR_W x WIDTH register file, one write port, two independent read ports, register 0 hardwired to zero.
// Latency : reads are combinational (0 cycles); a write lands at the rising edge and is visible from the next cycle.
// Backpres: none -- every cycle accepts one write and serves two reads; reset clears all state and beats a same-edge write.
//
// Ports:
//   clk                    single clock, all state changes on its rising edge
//   reset                  synchronous active-high clear of every register
//   wrenable               write-port enable
//   writeaddr / writedata  write-port index and data
//   readaddr1 / readdata1  read port 1 index and data
//   readaddr2 / readdata2  read port 2 index and data
//
// Build option: define REGISTER_FILE_BYPASS_EN to forward writedata to a read port whose
// address matches a live, non-zero write in the same cycle. Undefined: reads return stored
// contents only, so a read of the address being written shows the old value.

module register_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrenable,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [WIDTH-1:0]  writedata,
    input  logic [ADDR_W-1:0] readaddr1,
    input  logic [ADDR_W-1:0] readaddr2,
    output logic [WIDTH-1:0]  readdata1,
    output logic [WIDTH-1:0]  readdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    // A write to address 0 is dropped here so entry 0 can never hold anything but zero.
    logic wr_hit;
    assign wr_hit = wrenable && (writeaddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_hit) begin
            regs_d[writeaddr] = writedata;
        end
        regs_d[0] = '0;
    end

    // Reset takes priority over any write presented on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= reset ? '0 : regs_d[i];
        end
    end

    // Address 0 is forced to zero on the read side as well, independent of the
    // storage contents, so the zero register holds even if entry 0 were disturbed.
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;
    assign stored1 = (readaddr1 == '0) ? '0 : regs_q[readaddr1];
    assign stored2 = (readaddr2 == '0) ? '0 : regs_q[readaddr2];

`ifdef REGISTER_FILE_BYPASS_EN
    // Forward only a write that will actually commit: enabled, non-zero address, no reset.
    logic byp_vld;
    assign byp_vld   = wr_hit && !reset;
    assign readdata1 = (byp_vld && (readaddr1 == writeaddr)) ? writedata : stored1;
    assign readdata2 = (byp_vld && (readaddr2 == writeaddr)) ? writedata : stored2;
`else
    assign readdata1 = stored1;
    assign readdata2 = stored2;
`endif

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus randomized traffic against an
// array-based reference model, on a 32x32 instance and an 8x8 instance.
// Inputs change just after the falling edge; outputs are sampled 1ns later.

module tb_register_file;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit x 32-entry instance
    logic        reset, wrenable;
    logic [4:0]  writeaddr, readaddr1, readaddr2;
    logic [31:0] writedata, readdata1, readdata2;

    // 8-bit x 8-entry instance
    logic       s_reset, s_wrenable;
    logic [2:0] s_writeaddr, s_readaddr1, s_readaddr2;
    logic [7:0] s_writedata, s_readdata1, s_readdata2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference contents: index 0 is never written, so it stays zero.
    logic [31:0] mem  [32];
    logic [7:0]  smem [8];

    register_file #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .wrenable(wrenable),
        .writeaddr(writeaddr), .writedata(writedata),
        .readaddr1(readaddr1), .readaddr2(readaddr2),
        .readdata1(readdata1), .readdata2(readdata2)
    );

    register_file #(.WIDTH(8), .ADDR_W(3)) dut_s (
        .clk(clk), .reset(s_reset), .wrenable(s_wrenable),
        .writeaddr(s_writeaddr), .writedata(s_writedata),
        .readaddr1(s_readaddr1), .readaddr2(s_readaddr2),
        .readdata1(s_readdata1), .readdata2(s_readdata2)
    );

    // Advance one rising edge, leaving the bench just after the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset = 0; wrenable = 0; writeaddr = 0; writedata = 0; readaddr1 = 0; readaddr2 = 0;
        s_reset = 0; s_wrenable = 0; s_writeaddr = 0; s_writedata = 0; s_readaddr1 = 0; s_readaddr2 = 0;
    endtask

    // Expected read value from the reference: stored contents, or the live write
    // data when forwarding is built in and the write will commit this edge.
    function automatic logic [31:0] exp_big(input logic [4:0] a);
        if (BYP && wrenable && !reset && a != 0 && a == writeaddr) return writedata;
        return mem[a];
    endfunction

    function automatic logic [7:0] exp_small(input logic [2:0] a);
        if (BYP && s_wrenable && !s_reset && a != 0 && a == s_writeaddr) return s_writedata;
        return smem[a];
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1; s_reset = 1;
        wrenable = 1; writeaddr = 5'd9; writedata = 32'h0BAD_F00D;
        tick();
        tick();
        reset = 0; s_reset = 0; wrenable = 0;
        for (int i = 0; i < 32; i++) begin
            readaddr1 = 5'(i); readaddr2 = 5'(31 - i);
            #1;
            vectors++;
            if (readdata1 !== 32'h0 || readdata2 !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_read a=%0d: got %h/%h want 0/0", i, readdata1, readdata2);
            end
        end
        for (int i = 0; i < 8; i++) begin
            s_readaddr1 = 3'(i); s_readaddr2 = 3'(7 - i);
            #1;
            vectors++;
            if (s_readdata1 !== 8'h0 || s_readdata2 !== 8'h0) begin
                miscompares++;
                $display("FAIL reset_read_small a=%0d: got %h/%h want 0/0", i, s_readdata1, s_readdata2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        wrenable = 1; writeaddr = 5'd7; writedata = 32'hDEAD_BEEF;
        readaddr1 = 0; readaddr2 = 0;
        tick();
        wrenable = 0;
        readaddr1 = 5'd7; readaddr2 = 5'd7;
        #1;
        vectors++;
        if (readdata1 !== 32'hDEAD_BEEF || readdata2 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL write_read a=7: got %h/%h want deadbeef/deadbeef", readdata1, readdata2);
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 7) continue;
            readaddr1 = 5'(i); readaddr2 = 5'(31 - i);
            #1;
            vectors++;
            if (readdata1 !== 32'h0 || (readdata2 !== ((31 - i) == 7 ? 32'hDEAD_BEEF : 32'h0))) begin
                miscompares++;
                $display("FAIL others_zero a=%0d/%0d: got %h/%h", i, 31 - i, readdata1, readdata2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        wrenable = 1; writeaddr = 5'd0; writedata = 32'hFFFF_FFFF;
        readaddr1 = 5'd0; readaddr2 = 5'd7;
        #1;
        vectors++;
        if (readdata1 !== 32'h0 || readdata2 !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL zero_write_cycle: got %h/%h want 0/deadbeef", readdata1, readdata2);
        end
        tick();
        wrenable = 0;
        readaddr2 = 5'd0;
        #1;
        vectors++;
        if (readdata1 !== 32'h0 || readdata2 !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_after_write: got %h/%h want 0/0", readdata1, readdata2);
        end
        @(negedge clk);
    endtask

    task automatic test_read_during_write();
        logic [31:0] want;
        wrenable = 1; writeaddr = 5'd3; writedata = 32'hA5A5_A5A5;
        tick();
        writedata = 32'h1234_5678;
        readaddr1 = 5'd3; readaddr2 = 5'd3;
        want = BYP ? 32'h1234_5678 : 32'hA5A5_A5A5;
        #1;
        vectors++;
        if (readdata1 !== want || readdata2 !== want) begin
            miscompares++;
            $display("FAIL rdw_same_cycle: got %h/%h want %h", readdata1, readdata2, want);
        end
        tick();
        wrenable = 0;
        #1;
        vectors++;
        if (readdata1 !== 32'h1234_5678 || readdata2 !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rdw_next_cycle: got %h/%h want 12345678", readdata1, readdata2);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [3];
        logic [31:0] prev;
        logic [31:0] want;
        v[0] = 32'h1111_0001; v[1] = 32'h2222_0002; v[2] = 32'h3333_0003;
        prev = 32'h0;
        readaddr1 = 5'd12; readaddr2 = 5'd12;
        for (int k = 0; k < 3; k++) begin
            wrenable = 1; writeaddr = 5'd12; writedata = v[k];
            want = BYP ? v[k] : prev;
            #1;
            vectors++;
            if (readdata1 !== want || readdata2 !== want) begin
                miscompares++;
                $display("FAIL b2b_write%0d: got %h/%h want %h", k, readdata1, readdata2, want);
            end
            prev = v[k];
            tick();
        end
        wrenable = 0;
        #1;
        vectors++;
        if (readdata1 !== 32'h3333_0003 || readdata2 !== 32'h3333_0003) begin
            miscompares++;
            $display("FAIL b2b_final: got %h/%h want 33330003", readdata1, readdata2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_priority();
        wrenable = 1; writeaddr = 5'd4; writedata = 32'h77;
        tick();
        // Reset edge carrying a write: bypass must not forward during reset either.
        reset = 1; writedata = 32'h55;
        readaddr1 = 5'd4; readaddr2 = 5'd3;
        #1;
        vectors++;
        if (readdata1 !== 32'h77 || readdata2 !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL reset_cycle_read: got %h/%h want 77/12345678", readdata1, readdata2);
        end
        tick();
        reset = 0; wrenable = 0;
        for (int i = 0; i < 32; i++) begin
            readaddr1 = 5'(i); readaddr2 = 5'd4;
            #1;
            vectors++;
            if (readdata1 !== 32'h0 || readdata2 !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_overrides_write a=%0d: got %h/%h want 0/0", i, readdata1, readdata2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fill_pairs();
        for (int i = 1; i < 32; i++) begin
            wrenable = 1; writeaddr = 5'(i); writedata = 32'(i);
            if (i < 8) begin
                s_wrenable = 1; s_writeaddr = 3'(i); s_writedata = 8'(i);
            end else begin
                s_wrenable = 0;
            end
            tick();
        end
        wrenable = 0; s_wrenable = 0;
        for (int i = 1; i < 32; i++) begin
            readaddr1 = 5'(i); readaddr2 = 5'(32 - i);
            #1;
            vectors++;
            if (readdata1 !== 32'(i) || readdata2 !== 32'(32 - i)) begin
                miscompares++;
                $display("FAIL fill_pair %0d/%0d: got %0d/%0d", i, 32 - i, readdata1, readdata2);
            end
        end
        for (int i = 1; i < 8; i++) begin
            s_readaddr1 = 3'(i); s_readaddr2 = 3'(8 - i);
            #1;
            vectors++;
            if (s_readdata1 !== 8'(i) || s_readdata2 !== 8'(8 - i)) begin
                miscompares++;
                $display("FAIL fill_pair_small %0d/%0d: got %0d/%0d", i, 8 - i, s_readdata1, s_readdata2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic [7:0]  f1, f2;
        // Start from a known state shared with the reference.
        idle_inputs();
        reset = 1; s_reset = 1;
        tick();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) smem[i] = '0;
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 39) == 0);
            wrenable    = ($urandom_range(0, 2) != 0);
            writeaddr   = 5'($urandom_range(0, 31));
            writedata   = $urandom;
            readaddr1   = ($urandom_range(0, 3) == 0) ? writeaddr : 5'($urandom_range(0, 31));
            readaddr2   = ($urandom_range(0, 3) == 0) ? writeaddr : 5'($urandom_range(0, 31));
            s_reset     = ($urandom_range(0, 39) == 0);
            s_wrenable  = ($urandom_range(0, 2) != 0);
            s_writeaddr = 3'($urandom_range(0, 7));
            s_writedata = 8'($urandom);
            s_readaddr1 = ($urandom_range(0, 3) == 0) ? s_writeaddr : 3'($urandom_range(0, 7));
            s_readaddr2 = ($urandom_range(0, 3) == 0) ? s_writeaddr : 3'($urandom_range(0, 7));
            #1;
            e1 = exp_big(readaddr1);  e2 = exp_big(readaddr2);
            f1 = exp_small(s_readaddr1); f2 = exp_small(s_readaddr2);
            vectors++;
            if (readdata1 !== e1 || readdata2 !== e2) begin
                miscompares++;
                $display("FAIL random_big n=%0d a=%0d/%0d: got %h/%h want %h/%h",
                         n, readaddr1, readaddr2, readdata1, readdata2, e1, e2);
            end
            vectors++;
            if (s_readdata1 !== f1 || s_readdata2 !== f2) begin
                miscompares++;
                $display("FAIL random_small n=%0d a=%0d/%0d: got %h/%h want %h/%h",
                         n, s_readaddr1, s_readaddr2, s_readdata1, s_readdata2, f1, f2);
            end
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 32; i++) mem[i] = '0;
            end else if (wrenable && writeaddr != 0) begin
                mem[writeaddr] = writedata;
            end
            if (s_reset) begin
                for (int i = 0; i < 8; i++) smem[i] = '0;
            end else if (s_wrenable && s_writeaddr != 0) begin
                smem[s_writeaddr] = s_writedata;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_zero_reg();
        test_read_during_write();
        test_back_to_back();
        test_reset_priority();
        test_fill_pairs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
